neuron_in_stager: RTL and testbench



---
 rtl/neuron_pkg.sv | 19 +
 rtl/neuron_slot_reg.sv | 37 +++
 rtl/neuron_in_stager.sv | 118 +++++++++++
 tb/tb_neuron_in_stager.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron input stager and its reference models.
package neuron_pkg;

  localparam int DW_DEF = 8;
  localparam int OW_DEF = 16;

  // Stager FSM encodings
  localparam logic [1:0] FILL = 2'd0;
  localparam logic [1:0] EVAL = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  // Neuron weights and bias, for reference models outside the stager
  localparam int W0   = -5;
  localparam int W1   = 10;
  localparam int W2   = 27;
  localparam int W3   = -13;
  localparam int BIAS = 7;

endpackage

// File: rtl/neuron_slot_reg.sv
// Bank of N_IN activation slots: indexed write, zero-fill above the written
// index (short vectors) and a whole-bank clear.
module neuron_slot_reg
  import neuron_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int DW   = DW_DEF,
  parameter int CNTW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     we,
  input  logic                     zfill,
  input  logic [CNTW-1:0]          idx,
  input  logic [DW-1:0]            din,
  output logic [N_IN-1:0][DW-1:0]  q
);

  // Clear beats write; a write with zfill also zeroes every slot above idx
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (we) begin
      for (int i = 0; i < N_IN; i++) begin
        if (CNTW'(i) == idx) begin
          q[i] <= din;
        end else if (zfill && (CNTW'(i) > idx)) begin
          q[i] <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/neuron_in_stager.sv
// Flow-controlled stage around the combinational neuron: assembles a byte
// stream into a parallel vector, holds it for one evaluation cycle, registers
// the result and offers it downstream.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, is held with its data until that edge, and
// ready may depend on state but never on valid.
module neuron_in_stager
  import neuron_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int DW   = DW_DEF,
  parameter int OW   = OW_DEF,
  parameter int CW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          s_last,
  output logic [DW-1:0] inp0,
  output logic [DW-1:0] inp1,
  output logic [DW-1:0] inp2,
  output logic [DW-1:0] inp3,
  input  logic [OW-1:0] nrn_out,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic [CW-1:0] vec_cnt,
  output logic [1:0]    state_dbg
);

  localparam int CNTW = (N_IN > 1) ? $clog2(N_IN) : 1;

  logic [1:0]                state;
  logic [CNTW-1:0]           cnt;
  logic                      alive;
  logic [N_IN-1:0][DW-1:0]   slots;
  logic                      in_hs;
  logic                      out_hs;
  logic                      last_slot;
  logic                      slot_clr;

  assign s_ready   = alive && (state == FILL);
  assign m_valid   = (state == OUT);
  assign in_hs     = s_valid && s_ready && !flush;
  assign out_hs    = m_valid && m_ready && !flush;
  assign last_slot = (cnt == CNTW'(N_IN - 1));
  assign slot_clr  = flush || out_hs;
  assign state_dbg = state;

  // Slot outputs feed the neuron directly so the vector never glitches
  assign inp0 = slots[0];
  assign inp1 = slots[1];
  assign inp2 = slots[2];
  assign inp3 = slots[3];

  neuron_slot_reg #(
    .N_IN (N_IN),
    .DW   (DW),
    .CNTW (CNTW)
  ) u_slots (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (slot_clr),
    .we    (in_hs),
    .zfill (s_last),
    .idx   (cnt),
    .din   (s_data),
    .q     (slots)
  );

  // Holds s_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alive <= 1'b0;
    else        alive <= 1'b1;
  end

  // Main FSM: fill slots, one evaluation cycle, then hold the result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FILL;
      cnt     <= '0;
      m_data  <= '0;
      vec_cnt <= '0;
    end else if (flush) begin
      state <= FILL;
      cnt   <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_hs) begin
            cnt <= cnt + 1'b1;
            if (last_slot || s_last) state <= EVAL;
          end
        end
        EVAL: begin
          m_data <= nrn_out;
          cnt    <= '0;
          state  <= OUT;
        end
        OUT: begin
          if (m_ready) begin
            vec_cnt <= vec_cnt + 1'b1;
            state   <= FILL;
          end
        end
        default: begin
          state <= FILL;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_in_stager.sv
// Bench for neuron_in_stager: table of vectors plus hand-written corner
// sequences, with a result scoreboard fed by a behavioural neuron.
module tb_neuron_in_stager;
  import neuron_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_last;
  logic [7:0]  inp0, inp1, inp2, inp3;
  logic [15:0] nrn_out;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [15:0] vec_cnt;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_vec  = 0;
  logic [15:0] exp_q[$];

  typedef struct {
    logic [7:0]  b[4];
    int          n;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[12];

  neuron_in_stager dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
    .inp0      (inp0),
    .inp1      (inp1),
    .inp2      (inp2),
    .inp3      (inp3),
    .nrn_out   (nrn_out),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .vec_cnt   (vec_cnt),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural neuron (environment, not a checker)
  always_comb begin
    int acc;
    acc = W0 * $signed(inp0) + W1 * $signed(inp1) + W2 * $signed(inp2)
        + W3 * $signed(inp3) + BIAS;
    nrn_out = (acc < 0) ? 16'd0 : acc[15:0];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int b0, input int b1, input int b2, input int b3,
                              input int n, input int exp);
    vec_t v;
    v.b[0] = b0[7:0];
    v.b[1] = b1[7:0];
    v.b[2] = b2[7:0];
    v.b[3] = b3[7:0];
    v.n    = n;
    v.exp  = exp[15:0];
    return v;
  endfunction

  // scoreboard: compare every accepted result against the expected queue
  always @(negedge clk) begin
    if (rst_n && m_valid && m_ready && !flush) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {16'd0, m_data}, 32'hFFFF_FFFF);
      end else begin
        check("m_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
      end
      exp_vec++;
    end
  end

  // drivers
  task automatic send_byte(input logic [7:0] d, input logic last);
    int k;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    if (k == 50) check("s_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    exp_q.push_back(v.exp);
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.b[i], (i == v.n - 1) && (v.n < 4));
    end
  endtask

  task automatic wait_valid();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    if (k == 50) check("m_valid_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = mk(10,   0,   0,  10, 4,    0);
    tbl[1]  = mk( 0,   0,   0,   0, 4,    7);
    tbl[2]  = mk(-1,   0,   0,   0, 4,   12);
    tbl[3]  = mk( 0,   1,   0,   0, 4,   17);
    tbl[4]  = mk( 0,   0,   1,   0, 4,   34);
    tbl[5]  = mk( 0,   0,   0,   1, 4,    0);
    tbl[6]  = mk(-128, 0,   0,   0, 4,  647);
    tbl[7]  = mk( 0,   0, 127,   0, 4, 3436);
    tbl[8]  = mk(-128, 127, 127, -128, 4, 7010);
    tbl[9]  = mk( 0,   0,   2,   0, 3,   61);
    tbl[10] = mk(-2,   0,   0,   0, 1,   17);
    tbl[11] = mk( 3,   0,   0,   0, 1,    0);

    rst_n = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    m_ready = 1'b1;
    #22;
    check("rst_s_ready", {31'd0, s_ready}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data", {16'd0, m_data}, 32'd0);
    check("rst_vec_cnt", {16'd0, vec_cnt}, 32'd0);
    check("rst_inp", {inp0, inp1, inp2, inp3}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, {30'd0, FILL});
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("s_ready_after_rst", {31'd0, s_ready}, 32'd1);

    // first vector with latency and EVAL-vector checks
    send_vec(mk(1, 2, 3, 4, 4, 51));
    check("eval_state", {30'd0, state_dbg}, {30'd0, EVAL});
    check("eval_inp", {inp0, inp1, inp2, inp3}, 32'h01020304);
    check("eval_m_valid", {31'd0, m_valid}, 32'd0);
    check("eval_s_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk); #1;
    check("lat_m_valid", {31'd0, m_valid}, 32'd1);
    check("lat_m_data", {16'd0, m_data}, 32'd51);
    @(posedge clk); #1;
    check("vec_cnt_1", {16'd0, vec_cnt}, 32'd1);
    check("back_to_fill", {30'd0, state_dbg}, {30'd0, FILL});

    // short vector zero-fill
    send_vec(mk(1, 1, 0, 0, 2, 12));
    check("short_eval_state", {30'd0, state_dbg}, {30'd0, EVAL});
    check("short_inp", {inp0, inp1, inp2, inp3}, 32'h01010000);
    wait_valid();

    // table
    for (int t = 0; t < 12; t++) begin
      send_vec(tbl[t]);
      wait_valid();
    end
    @(posedge clk); #1;
    check("vec_cnt_table", {16'd0, vec_cnt}, exp_vec[31:0] & 32'hFFFF);

    // downstream stall with a byte offered meanwhile
    m_ready = 1'b0;
    send_vec(mk(1, 2, 3, 4, 4, 51));
    wait_valid();
    s_valid = 1'b1; s_data = 8'd2; s_last = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("stall_m_valid", {31'd0, m_valid}, 32'd1);
      check("stall_m_data", {16'd0, m_data}, 32'd51);
      check("stall_s_ready", {31'd0, s_ready}, 32'd0);
      check("stall_inp0", {24'd0, inp0}, 32'd1);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    send_vec(mk(2, 1, 1, 0, 4, 34));
    wait_valid();

    // flush a partial vector, with a handshake in the flush cycle
    send_byte(8'd5, 1'b0);
    send_byte(8'd5, 1'b0);
    s_valid = 1'b1; s_data = 8'd7; flush = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; flush = 1'b0;
    check("flush_inp", {inp0, inp1, inp2, inp3}, 32'd0);
    check("flush_state", {30'd0, state_dbg}, {30'd0, FILL});
    send_vec(mk(1, 2, 3, 4, 4, 51));
    wait_valid();
    @(posedge clk); #1;
    check("vec_cnt_flush", {16'd0, vec_cnt}, exp_vec[31:0] & 32'hFFFF);

    // flush while holding a result
    m_ready = 1'b0;
    send_vec(mk(1, 2, 3, 4, 4, 51));
    wait_valid();
    flush = 1'b1;
    void'(exp_q.pop_back());
    @(posedge clk); #1;
    flush = 1'b0;
    m_ready = 1'b1;
    check("flush_out_m_valid", {31'd0, m_valid}, 32'd0);
    check("flush_out_vec_cnt", {16'd0, vec_cnt}, exp_vec[31:0] & 32'hFFFF);

    // asynchronous reset in the middle of EVAL
    send_vec(mk(1, 2, 3, 4, 4, 51));
    check("pre_rst_state", {30'd0, state_dbg}, {30'd0, EVAL});
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    exp_vec = 0;
    check("arst_inp", {inp0, inp1, inp2, inp3}, 32'd0);
    check("arst_m_valid", {31'd0, m_valid}, 32'd0);
    check("arst_m_data", {16'd0, m_data}, 32'd0);
    check("arst_s_ready", {31'd0, s_ready}, 32'd0);
    check("arst_vec_cnt", {16'd0, vec_cnt}, 32'd0);
    check("arst_state", {30'd0, state_dbg}, {30'd0, FILL});
    @(negedge clk);
    rst_n = 1'b1;
    send_vec(mk(1, 2, 3, 4, 4, 51));
    wait_valid();
    @(posedge clk); #1;
    check("post_rst_vec_cnt", {16'd0, vec_cnt}, 32'd1);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
